// File: rtl/hpu_buf_pkg.sv
// Shared definitions for the HPU operand/result buffers (src_buf, dst_buf).
// Holds the drain FSM state encoding, bank geometry and address widths.
package hpu_buf_pkg;

    // Bank geometry: 512 entries of 64 bits, stored as two 32-bit halves.
    localparam int BANK_DEPTH  = 512;
    localparam int IDX_W       = 9;
    localparam int HALF_W      = 32;
    localparam int WORD_W      = 64;

    // exec_dst_addr = {bank, index, half}
    localparam int EXEC_ADDR_W = 11;
    // dst_a = {bank, index}
    localparam int DST_A_W     = 10;
    // Drain length in 64-bit words, 1..512.
    localparam int LEN_W       = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } buf_state_e;

    function automatic logic [DST_A_W-1:0] make_dst_a(input logic bank,
                                                      input logic [IDX_W-1:0] idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/dst_buf_if.sv
// Host-side result stream of dst_buf.
//   dst_v     word valid              (master -> slave)
//   dst_ready host accepts the word   (slave  -> master)
//   dst_a     {bank, index} of word   (master -> slave)
//   dst_d     {odd half, even half}   (master -> slave)
//   dst_last  final word of the drain (master -> slave)
// Handshake: a word transfers on a rising edge where dst_v & dst_ready are
// both 1. Once dst_v is raised, dst_v/dst_a/dst_d/dst_last stay unchanged
// until that transfer; dst_v never depends combinationally on dst_ready.
interface dst_buf_if;
    import hpu_buf_pkg::*;

    logic               dst_v;
    logic               dst_ready;
    logic [DST_A_W-1:0] dst_a;
    logic [WORD_W-1:0]  dst_d;
    logic               dst_last;

    modport master (
        output dst_v, dst_a, dst_d, dst_last,
        input  dst_ready
    );

    modport slave (
        input  dst_v, dst_a, dst_d, dst_last,
        output dst_ready
    );

endinterface

// File: rtl/dst_buf_bank.sv
// One result bank: 512 x 64 bits held as separate even [31:0] and odd [63:32]
// arrays. 32-bit write port selects a half; 64-bit registered read port
// returns both halves of one index. A write and a read of the same location
// on the same edge returns the old contents (read-first).
// Ports:
//   clk      clock
//   we       write strobe
//   wr_idx   write index
//   wr_half  0 = even half, 1 = odd half
//   wr_data  32-bit write data
//   re       read enable; rd_data holds its value while re = 0
//   rd_idx   read index
//   rd_data  {odd, even} registered read data
// Contents are deliberately not reset.
module dst_buf_bank
    import hpu_buf_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              wr_half,
    input  logic [HALF_W-1:0] wr_data,
    input  logic              re,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [HALF_W-1:0] even_mem [BANK_DEPTH];
    logic [HALF_W-1:0] odd_mem  [BANK_DEPTH];

    always_ff @(posedge clk) begin
        if (we && !wr_half) begin
            even_mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (we && wr_half) begin
            odd_mem[wr_idx] <= wr_data;
        end
    end

    // Non-blocking update of the arrays makes this read see pre-write data.
    always_ff @(posedge clk) begin
        if (re) begin
            rd_data <= {odd_mem[rd_idx], even_mem[rd_idx]};
        end
    end

endmodule

// File: rtl/dst_buf.sv
// Result buffer: the core writes 32-bit results into two 512 x 64 banks; on
// request a bank prefix (drain_len words from index 0) is streamed to the
// host over a valid/ready interface through a two-stage pipeline
// (RAM read register, output register) sharing one advance enable.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   exec             result write strobe
//   exec_dst_addr    {bank, index, half}
//   exec_dst_data    32-bit result
//   drain_start      one-cycle drain request (ignored unless IDLE, len != 0)
//   drain_bank       bank to drain, sampled with drain_start
//   drain_len        words to drain 1..512, sampled with drain_start
//   drain_busy       drain in progress
//   drain_done       one-cycle pulse after the final word handshake
//   dst              host stream (dst_v, dst_ready, dst_a, dst_d, dst_last)
//   dbg_state        current drain FSM state
module dst_buf
    import hpu_buf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exec,
    input  logic [EXEC_ADDR_W-1:0] exec_dst_addr,
    input  logic [HALF_W-1:0]      exec_dst_data,
    input  logic                   drain_start,
    input  logic                   drain_bank,
    input  logic [LEN_W-1:0]       drain_len,
    output logic                   drain_busy,
    output logic                   drain_done,
    dst_buf_if.master              dst,
    output buf_state_e             dbg_state
);

    buf_state_e         state, state_nxt;
    logic               start_accept;
    logic               issue;
    logic               advance;
    logic               hs_last;

    logic               bank_q;
    logic [IDX_W-1:0]   rd_idx;
    logic [LEN_W-1:0]   remaining;

    // Stage 1: describes the word currently held in the bank read registers.
    logic               s1_v;
    logic [DST_A_W-1:0] s1_a;
    logic               s1_last;

    logic [WORD_W-1:0]  rd_data0, rd_data1, rd_sel;
    logic               we0, we1, re0, re1;

    // Both stages move together; a held output word freezes the read stage
    // too, which keeps the bank read registers stable during a stall.
    assign advance = ~dst.dst_v | dst.dst_ready;
    assign hs_last = dst.dst_v & dst.dst_ready & dst.dst_last;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_accept = 1'b0;
        issue        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (drain_start && (drain_len != '0)) begin
                    start_accept = 1'b1;
                    state_nxt    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    issue = 1'b1;
                    if (remaining == 10'd1) begin
                        state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (hs_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dbg_state  = state;
    assign drain_busy = (state != ST_IDLE);

    // ---------------- read address generation ----------------
    // rd_idx wraps after index 511 only once the FSM has left RUN, so a
    // 512-word drain never re-reads index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q    <= 1'b0;
            rd_idx    <= '0;
            remaining <= '0;
        end else if (start_accept) begin
            bank_q    <= drain_bank;
            rd_idx    <= '0;
            remaining <= drain_len;
        end else if (issue) begin
            rd_idx    <= rd_idx + 9'd1;
            remaining <= remaining - 10'd1;
        end
    end

    // ---------------- banks ----------------
    assign we0 = exec & ~exec_dst_addr[EXEC_ADDR_W-1];
    assign we1 = exec &  exec_dst_addr[EXEC_ADDR_W-1];
    assign re0 = issue & ~bank_q;
    assign re1 = issue &  bank_q;

    dst_buf_bank u_bank0 (
        .clk     (clk),
        .we      (we0),
        .wr_idx  (exec_dst_addr[IDX_W:1]),
        .wr_half (exec_dst_addr[0]),
        .wr_data (exec_dst_data),
        .re      (re0),
        .rd_idx  (rd_idx),
        .rd_data (rd_data0)
    );

    dst_buf_bank u_bank1 (
        .clk     (clk),
        .we      (we1),
        .wr_idx  (exec_dst_addr[IDX_W:1]),
        .wr_half (exec_dst_addr[0]),
        .wr_data (exec_dst_data),
        .re      (re1),
        .rd_idx  (rd_idx),
        .rd_data (rd_data1)
    );

    assign rd_sel = s1_a[DST_A_W-1] ? rd_data1 : rd_data0;

    // ---------------- stage 1 ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_a    <= '0;
            s1_last <= 1'b0;
        end else if (advance) begin
            s1_v <= issue;
            if (issue) begin
                s1_a    <= make_dst_a(bank_q, rd_idx);
                s1_last <= (remaining == 10'd1);
            end
        end
    end

    // ---------------- stage 2 (output register) ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst.dst_v    <= 1'b0;
            dst.dst_a    <= '0;
            dst.dst_d    <= '0;
            dst.dst_last <= 1'b0;
        end else if (advance) begin
            dst.dst_v    <= s1_v;
            dst.dst_last <= s1_v & s1_last;
            if (s1_v) begin
                dst.dst_a <= s1_a;
                dst.dst_d <= rd_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_done <= 1'b0;
        end else begin
            drain_done <= hs_last;
        end
    end

endmodule

// File: tb/tb_dst_buf.sv
module tb_dst_buf;
    import hpu_buf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exec = 1'b0;
    logic [10:0] exec_dst_addr = '0;
    logic [31:0] exec_dst_data = '0;
    logic        drain_start = 1'b0;
    logic        drain_bank = 1'b0;
    logic [9:0]  drain_len = '0;
    logic        drain_busy;
    logic        drain_done;
    buf_state_e  dbg_state;

    dst_buf_if dif ();

    int vectors = 0;
    int miscompares = 0;

    logic [9:0]  rx_a_q[$];
    logic [63:0] rx_d_q[$];
    logic        rx_last_q[$];

    dst_buf dut (
        .clk           (clk),
        .rst           (rst),
        .exec          (exec),
        .exec_dst_addr (exec_dst_addr),
        .exec_dst_data (exec_dst_data),
        .drain_start   (drain_start),
        .drain_bank    (drain_bank),
        .drain_len     (drain_len),
        .drain_busy    (drain_busy),
        .drain_done    (drain_done),
        .dst           (dif),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Bench model of the words written by the stall test.
    function automatic logic [63:0] pat_word(input int i);
        return {32'hB000_0000 | 32'(i), 32'hA000_0000 | 32'(i)};
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic exec_write(input logic [10:0] addr, input logic [31:0] data);
        exec          = 1'b1;
        exec_dst_addr = addr;
        exec_dst_data = data;
        @(negedge clk);
        exec = 1'b0;
    endtask

    // Starts a drain at the current negedge and collects every handshake.
    // pat 0: dst_ready always 1; pat 1: ready only on every third cycle.
    // cyc counts negedges after the start negedge; an exec write can be
    // placed at negedge inj_cyc (lands on the following rising edge).
    task automatic drain_collect(input logic bank, input logic [9:0] len,
                                 input int pat, input int budget,
                                 input int inj_cyc, input logic [10:0] inj_addr,
                                 input logic [31:0] inj_data,
                                 output bit timeout, output int stall_errs,
                                 output int first_cyc, output int last_hs_cyc,
                                 output int done_gap, output bit busy_bad);
        logic        prev_v, prev_r, prev_last;
        logic [9:0]  prev_a;
        logic [63:0] prev_d;
        bit          have_prev;
        rx_a_q.delete();
        rx_d_q.delete();
        rx_last_q.delete();
        timeout = 1'b1; stall_errs = 0; first_cyc = -1; last_hs_cyc = -1;
        done_gap = -1; busy_bad = 1'b0; have_prev = 1'b0;
        prev_v = 1'b0; prev_r = 1'b0; prev_last = 1'b0; prev_a = '0; prev_d = '0;
        drain_start = 1'b1;
        drain_bank  = bank;
        drain_len   = len;
        dif.dst_ready = (pat == 0) ? 1'b1 : 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (cyc == 1) drain_start = 1'b0;
            if (cyc == inj_cyc) begin
                exec = 1'b1; exec_dst_addr = inj_addr; exec_dst_data = inj_data;
            end else begin
                exec = 1'b0;
            end
            dif.dst_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (have_prev && prev_v && !prev_r) begin
                if (dif.dst_v !== 1'b1 || dif.dst_a !== prev_a ||
                    dif.dst_d !== prev_d || dif.dst_last !== prev_last)
                    stall_errs++;
            end
            if (dif.dst_v === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (drain_done === 1'b1) begin
                if (drain_busy !== 1'b0) busy_bad = 1'b1;
                done_gap = cyc - last_hs_cyc;
                timeout  = 1'b0;
                break;
            end
            if (drain_busy !== 1'b1) busy_bad = 1'b1;
            if (dif.dst_v === 1'b1 && dif.dst_ready === 1'b1) begin
                rx_a_q.push_back(dif.dst_a);
                rx_d_q.push_back(dif.dst_d);
                rx_last_q.push_back(dif.dst_last);
                if (dif.dst_last === 1'b1) last_hs_cyc = cyc;
            end
            prev_v = dif.dst_v; prev_r = dif.dst_ready; prev_last = dif.dst_last;
            prev_a = dif.dst_a; prev_d = dif.dst_d; have_prev = 1'b1;
        end
        exec = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (dif.dst_v !== 1'b0 || dif.dst_last !== 1'b0 || dif.dst_a !== 10'h0 ||
            dif.dst_d !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b last=%b a=%h d=%h, expected all 0",
                     dif.dst_v, dif.dst_last, dif.dst_a, dif.dst_d);
        end
        vectors++;
        if (drain_busy !== 1'b0 || drain_done !== 1'b0 || dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_ctrl: got busy=%b done=%b state=%0d, expected 0 0 0",
                     drain_busy, drain_done, dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit t, bb; int se, fc, lh, dg;
        exec_write(11'h000, 32'h1111_1111);
        exec_write(11'h001, 32'h2222_2222);
        drain_collect(1'b0, 10'd1, 0, 20, -1, '0, '0, t, se, fc, lh, dg, bb);
        vectors++;
        if (t || rx_d_q.size() != 1) begin
            miscompares++;
            $display("FAIL single_count: got timeout=%b words=%0d, expected 0 1", t, rx_d_q.size());
        end else begin
            vectors++;
            if (rx_d_q[0] !== 64'h2222_2222_1111_1111 || rx_a_q[0] !== 10'h000 || rx_last_q[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL single_word: got a=%h d=%h last=%b, expected 000 2222222211111111 1",
                         rx_a_q[0], rx_d_q[0], rx_last_q[0]);
            end
        end
        vectors++;
        if (fc != 3 || dg != 1 || bb) begin
            miscompares++;
            $display("FAIL single_timing: got first=%0d done_gap=%0d busy_bad=%b, expected 3 1 0", fc, dg, bb);
        end
    endtask

    task automatic test_full_bank();
        bit t, bb; int se, fc, lh, dg;
        logic [8:0] idx;
        for (int i = 0; i < 512; i++) begin
            idx = 9'(i);
            exec_write({1'b1, idx, 1'b0}, 32'(i));
            exec_write({1'b1, idx, 1'b1}, 32'(i + 1));
        end
        drain_collect(1'b1, 10'd512, 0, 600, -1, '0, '0, t, se, fc, lh, dg, bb);
        vectors++;
        if (t || rx_d_q.size() != 512) begin
            miscompares++;
            $display("FAIL full_count: got timeout=%b words=%0d, expected 0 512", t, rx_d_q.size());
        end else begin
            for (int i = 0; i < 512; i++) begin
                vectors++;
                if (rx_a_q[i] !== 10'(10'h200 + i) || rx_d_q[i] !== {32'(i + 1), 32'(i)} ||
                    rx_last_q[i] !== (i == 511)) begin
                    miscompares++;
                    $display("FAIL full_word[%0d]: got a=%h d=%h last=%b, expected a=%h d=%h last=%b",
                             i, rx_a_q[i], rx_d_q[i], rx_last_q[i], 10'(10'h200 + i),
                             {32'(i + 1), 32'(i)}, (i == 511));
                end
            end
        end
        vectors++;
        if (fc != 3 || lh != 514 || dg != 1 || bb) begin
            miscompares++;
            $display("FAIL full_timing: got first=%0d last_hs=%0d done_gap=%0d busy_bad=%b, expected 3 514 1 0",
                     fc, lh, dg, bb);
        end
    endtask

    task automatic test_stall();
        bit t, bb; int se, fc, lh, dg;
        logic [8:0] idx;
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            idx = 9'(i);
            w   = pat_word(i);
            exec_write({1'b0, idx, 1'b0}, w[31:0]);
            exec_write({1'b0, idx, 1'b1}, w[63:32]);
        end
        drain_collect(1'b0, 10'd8, 1, 60, -1, '0, '0, t, se, fc, lh, dg, bb);
        vectors++;
        if (t || rx_d_q.size() != 8 || se != 0) begin
            miscompares++;
            $display("FAIL stall_count: got timeout=%b words=%0d stall_errs=%0d, expected 0 8 0",
                     t, rx_d_q.size(), se);
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (rx_a_q[i] !== 10'(i) || rx_d_q[i] !== pat_word(i) || rx_last_q[i] !== (i == 7)) begin
                    miscompares++;
                    $display("FAIL stall_word[%0d]: got a=%h d=%h last=%b, expected a=%h d=%h last=%b",
                             i, rx_a_q[i], rx_d_q[i], rx_last_q[i], 10'(i), pat_word(i), (i == 7));
                end
            end
        end
        vectors++;
        if (lh != 24 || dg != 1) begin
            miscompares++;
            $display("FAIL stall_timing: got last_hs=%0d done_gap=%0d, expected 24 1", lh, dg);
        end
    endtask

    task automatic test_ignored_start();
        int  hs; bit seen_done; bit quiet_bad;
        // len = 0 from IDLE
        drain_start = 1'b1; drain_bank = 1'b0; drain_len = 10'd0; dif.dst_ready = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (dbg_state !== ST_IDLE || drain_busy !== 1'b0 || dif.dst_v !== 1'b0) begin
            miscompares++;
            $display("FAIL len0_ignored: got state=%0d busy=%b v=%b, expected 0 0 0",
                     dbg_state, drain_busy, dif.dst_v);
        end
        // active drain with host stalled
        drain_start = 1'b1; drain_bank = 1'b0; drain_len = 10'd4; dif.dst_ready = 1'b0;
        @(negedge clk);
        drain_start = 1'b0;
        vectors++;
        if (drain_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept: got %b expected 1", drain_busy);
        end
        @(negedge clk);
        @(negedge clk);
        drain_start = 1'b1; drain_bank = 1'b1; drain_len = 10'd5;
        @(negedge clk);
        drain_start = 1'b0;
        vectors++;
        if (dbg_state !== ST_RUN || dif.dst_v !== 1'b1 || dif.dst_a !== 10'h000 ||
            dif.dst_d !== pat_word(0) || dif.dst_last !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_ignored: got state=%0d v=%b a=%h d=%h last=%b, expected 1 1 000 %h 0",
                     dbg_state, dif.dst_v, dif.dst_a, dif.dst_d, dif.dst_last, pat_word(0));
        end
        // release the host and expect exactly the original 4 words
        rx_a_q.delete();
        dif.dst_ready = 1'b1;
        seen_done = 1'b0; hs = 0;
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            if (drain_done === 1'b1) seen_done = 1'b1;
            else if (dif.dst_v === 1'b1) rx_a_q.push_back(dif.dst_a);
            if (!seen_done) @(negedge clk);
        end
        hs = rx_a_q.size();
        vectors++;
        if (!seen_done || hs != 4) begin
            miscompares++;
            $display("FAIL busy_drain_words: got done=%b words=%0d, expected 1 4", seen_done, hs);
        end else begin
            vectors++;
            if (rx_a_q[0] !== 10'h0 || rx_a_q[1] !== 10'h1 || rx_a_q[2] !== 10'h2 || rx_a_q[3] !== 10'h3) begin
                miscompares++;
                $display("FAIL busy_drain_addr: got %h %h %h %h, expected 000 001 002 003",
                         rx_a_q[0], rx_a_q[1], rx_a_q[2], rx_a_q[3]);
            end
        end
        quiet_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (dif.dst_v !== 1'b0 || drain_busy !== 1'b0) quiet_bad = 1'b1;
        end
        vectors++;
        if (quiet_bad) begin
            miscompares++;
            $display("FAIL no_extra_drain: got activity after done, expected idle");
        end
    endtask

    task automatic test_read_first();
        bit t, bb; int se, fc, lh, dg;
        logic [63:0] exp_w;
        // index 5 is read on the 7th rising edge after the start negedge
        drain_collect(1'b0, 10'd8, 0, 30, 6, {1'b0, 9'd5, 1'b0}, 32'hDEAD_BEEF,
                      t, se, fc, lh, dg, bb);
        vectors++;
        if (t || rx_d_q.size() != 8) begin
            miscompares++;
            $display("FAIL rf_count: got timeout=%b words=%0d, expected 0 8", t, rx_d_q.size());
        end else begin
            vectors++;
            if (rx_d_q[5] !== pat_word(5) || rx_d_q[4] !== pat_word(4) || rx_d_q[6] !== pat_word(6)) begin
                miscompares++;
                $display("FAIL rf_old_value: got w4=%h w5=%h w6=%h, expected %h %h %h",
                         rx_d_q[4], rx_d_q[5], rx_d_q[6], pat_word(4), pat_word(5), pat_word(6));
            end
        end
        @(negedge clk);
        drain_collect(1'b0, 10'd8, 0, 30, -1, '0, '0, t, se, fc, lh, dg, bb);
        exp_w = {32'hB000_0005, 32'hDEAD_BEEF};
        vectors++;
        if (t || rx_d_q.size() != 8) begin
            miscompares++;
            $display("FAIL rf2_count: got timeout=%b words=%0d, expected 0 8", t, rx_d_q.size());
        end else begin
            vectors++;
            if (rx_d_q[5] !== exp_w || rx_d_q[6] !== pat_word(6)) begin
                miscompares++;
                $display("FAIL rf_new_value: got w5=%h w6=%h, expected %h %h",
                         rx_d_q[5], rx_d_q[6], exp_w, pat_word(6));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit t, bb; int se, fc, lh, dg;
        @(negedge clk);
        drain_collect(1'b0, 10'd2, 0, 20, -1, '0, '0, t, se, fc, lh, dg, bb);
        vectors++;
        if (t || rx_d_q.size() != 2 || rx_a_q[1] !== 10'h001 || rx_last_q[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first: got timeout=%b words=%0d, expected 0 2 ending at 001", t, rx_d_q.size());
        end
        // restart in the very cycle drain_done is high
        drain_collect(1'b1, 10'd3, 0, 20, -1, '0, '0, t, se, fc, lh, dg, bb);
        vectors++;
        if (t || rx_d_q.size() != 3 || fc != 3) begin
            miscompares++;
            $display("FAIL b2b_second: got timeout=%b words=%0d first=%0d, expected 0 3 3",
                     t, rx_d_q.size(), fc);
        end else begin
            vectors++;
            if (rx_a_q[2] !== 10'h202 || rx_d_q[2] !== {32'd3, 32'd2} || rx_last_q[2] !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_word: got a=%h d=%h last=%b, expected 202 0000000300000002 1",
                         rx_a_q[2], rx_d_q[2], rx_last_q[2]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit t, bb; int se, fc, lh, dg;
        int hs; bit done_seen;
        @(negedge clk);
        drain_start = 1'b1; drain_bank = 1'b1; drain_len = 10'd10; dif.dst_ready = 1'b1;
        hs = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) drain_start = 1'b0;
            if (hs == 3) break;
            if (dif.dst_v === 1'b1 && dif.dst_ready === 1'b1) hs++;
        end
        vectors++;
        if (hs != 3) begin
            miscompares++;
            $display("FAIL mid_reset_setup: got %0d handshakes, expected 3", hs);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (dif.dst_v !== 1'b0 || dif.dst_a !== 10'h0 || dif.dst_d !== 64'h0 || dif.dst_last !== 1'b0 ||
            drain_busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got v=%b a=%h d=%h last=%b busy=%b state=%0d, expected all 0",
                     dif.dst_v, dif.dst_a, dif.dst_d, dif.dst_last, drain_busy, dbg_state);
        end
        done_seen = 1'b0;
        @(negedge clk);
        if (drain_done !== 1'b0) done_seen = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (drain_done !== 1'b0 || dif.dst_v !== 1'b0) done_seen = 1'b1;
        end
        vectors++;
        if (done_seen) begin
            miscompares++;
            $display("FAIL mid_reset_no_done: got drain_done/dst_v activity, expected none");
        end
        drain_collect(1'b1, 10'd10, 0, 30, -1, '0, '0, t, se, fc, lh, dg, bb);
        vectors++;
        if (t || rx_d_q.size() != 10) begin
            miscompares++;
            $display("FAIL post_reset_count: got timeout=%b words=%0d, expected 0 10", t, rx_d_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                vectors++;
                if (rx_a_q[i] !== 10'(10'h200 + i) || rx_d_q[i] !== {32'(i + 1), 32'(i)} ||
                    rx_last_q[i] !== (i == 9)) begin
                    miscompares++;
                    $display("FAIL post_reset_word[%0d]: got a=%h d=%h last=%b, expected a=%h d=%h last=%b",
                             i, rx_a_q[i], rx_d_q[i], rx_last_q[i], 10'(10'h200 + i),
                             {32'(i + 1), 32'(i)}, (i == 9));
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        dif.dst_ready = 1'b0;
        test_reset();
        test_single();
        test_full_bank();
        test_stall();
        test_ignored_start();
        test_read_first();
        test_back_to_back();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
